// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU control unit.
// Runs each instruction through IF/ID/EXE/MEM/WB, drives the datapath
// control signals, gates the PC and IR writes, counts retired
// instructions, and parks in a HALT state until the next reset.
//
// Ports:
//   CLK        system clock, rising edge
//   Reset      synchronous active-high reset
//   OpCode     opcode field from the instruction register
//   zero/sign  ALU status flags (result == 0, result MSB)
//   PCWre      PC write enable
//   IRWre      instruction register write enable
//   InsMemRW   instruction memory read (1 = read)
//   ALUSrcA    1 = shift amount, 0 = rs
//   ALUSrcB    1 = extended immediate, 0 = rt
//   DBDataSrc  1 = data memory, 0 = ALU result
//   RegWre     register file write enable
//   RD / WR    data memory read / write strobes, active low
//   ExtSel     1 = sign-extend, 0 = zero-extend
//   RegDst     1 = rd, 0 = rt
//   PCSrc      00 = PC+4, 01 = branch target, 10 = jump target
//   ALUOp      ALU function select
//   state      current FSM state (debug)
//   halted     FSM is in HALT
//   retired    retired-instruction count (wraps)
//
// state    | code | meaning
// IF       | 000  | fetch, IR written
// ID       | 001  | decode; last state of j / NOP
// EXE_LS   | 010  | address calculation for lw / sw
// MEM      | 011  | data memory access
// WB_LD    | 100  | load write-back
// EXE_BR   | 101  | branch compare and PC update
// EXE_AL   | 110  | ALU execute
// WB_AL    | 111  | ALU write-back
// HALT     | 001  | ID code with halted = 1, held until reset

module multicycle_control_unit #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    OpCode,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               RegWre,
  output logic               RD,
  output logic               WR,
  output logic               ExtSel,
  output logic               RegDst,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state,
  output logic               halted,
  output logic [CNT_W-1:0]   retired
);

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010011);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b011100);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BLTZ = OP_W'(6'b110010);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'd5);

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_RALU,
    C_IALU,
    C_LW,
    C_SW,
    C_BR,
    C_J,
    C_HALT
  } class_t;

  state_t state_q, state_d;
  logic   halted_q, halted_d;

  class_t              cls;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic                dec_src_a;
  logic                dec_src_b;
  logic                dec_ext_sel;
  logic                dec_reg_dst;
  logic                dec_db_src;
  logic                br_taken;
  logic                sel_active;

  // Instruction decode: class plus the selects held from ID onward.
  always_comb begin
    cls         = C_NOP;
    dec_alu_op  = ALU_ADD;
    dec_src_a   = 1'b0;
    dec_src_b   = 1'b0;
    dec_ext_sel = 1'b1;
    dec_reg_dst = 1'b0;
    dec_db_src  = 1'b0;
    br_taken    = 1'b0;
    case (OpCode)
      OP_ADD:  begin cls = C_RALU; dec_alu_op = ALU_ADD; end
      OP_SUB:  begin cls = C_RALU; dec_alu_op = ALU_SUB; end
      OP_AND:  begin cls = C_RALU; dec_alu_op = ALU_AND; end
      OP_OR:   begin cls = C_RALU; dec_alu_op = ALU_OR;  end
      OP_SLL:  begin cls = C_RALU; dec_alu_op = ALU_SLL; dec_src_a = 1'b1; end
      OP_ADDI: begin cls = C_IALU; dec_alu_op = ALU_ADD; end
      OP_ORI:  begin cls = C_IALU; dec_alu_op = ALU_OR;  dec_ext_sel = 1'b0; end
      OP_ANDI: begin cls = C_IALU; dec_alu_op = ALU_AND; dec_ext_sel = 1'b0; end
      OP_SLTI: begin cls = C_IALU; dec_alu_op = ALU_SLT; end
      OP_SW:   begin cls = C_SW;   dec_alu_op = ALU_ADD; end
      OP_LW:   begin cls = C_LW;   dec_alu_op = ALU_ADD; dec_db_src = 1'b1; end
      OP_BEQ:  begin cls = C_BR;   dec_alu_op = ALU_SUB; br_taken = zero;  end
      OP_BNE:  begin cls = C_BR;   dec_alu_op = ALU_SUB; br_taken = !zero; end
      OP_BLTZ: begin cls = C_BR;   dec_alu_op = ALU_SUB; br_taken = sign;  end
      OP_J:    cls = C_J;
      OP_HALT: cls = C_HALT;
      default: cls = C_NOP;
    endcase
    if (cls == C_IALU || cls == C_LW || cls == C_SW) begin
      dec_src_b = 1'b1;
    end
    if (cls == C_RALU) begin
      dec_reg_dst = 1'b1;
    end
  end

  // Next state. HALT reuses the ID code, so it is tracked by halted_q.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        S_IF: state_d = S_ID;
        S_ID: begin
          case (cls)
            C_RALU, C_IALU: state_d = S_EXE_AL;
            C_BR:           state_d = S_EXE_BR;
            C_LW, C_SW:     state_d = S_EXE_LS;
            C_HALT:         halted_d = 1'b1;
            default:        state_d = S_IF;
          endcase
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL:  state_d = S_IF;
        S_EXE_BR: state_d = S_IF;
        S_EXE_LS: state_d = S_MEM;
        S_MEM:    state_d = (cls == C_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  state_d = S_IF;
        default:  state_d = S_IF;
      endcase
    end
  end

  // Mux selects and ALUOp are live for the whole instruction after IF,
  // and forced quiet while halted.
  assign sel_active = !halted_q && (state_q != S_IF);

  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    DBDataSrc = 1'b0;
    RegWre    = 1'b0;
    RD        = 1'b1;
    WR        = 1'b1;
    ExtSel    = 1'b0;
    RegDst    = 1'b0;
    PCSrc     = 2'b00;
    ALUOp     = ALU_ADD;
    if (sel_active) begin
      ALUOp     = dec_alu_op;
      ALUSrcA   = dec_src_a;
      ALUSrcB   = dec_src_b;
      ExtSel    = dec_ext_sel;
      RegDst    = dec_reg_dst;
      DBDataSrc = dec_db_src;
    end
    if (!halted_q) begin
      case (state_q)
        S_IF: begin
          IRWre    = 1'b1;
          InsMemRW = 1'b1;
        end
        S_ID: begin
          if (cls == C_J) begin
            PCWre = 1'b1;
            PCSrc = 2'b10;
          end else if (cls == C_NOP) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          if (br_taken) begin
            PCSrc = 2'b01;
          end
        end
        S_MEM: begin
          if (cls == C_LW) begin
            RD = 1'b0;
          end else begin
            WR    = 1'b0;
            PCWre = 1'b1;
          end
        end
        S_WB_AL, S_WB_LD: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= S_IF;
      halted_q <= 1'b0;
      retired  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      // PCWre marks the final cycle of an instruction.
      retired  <= retired + CNT_W'(PCWre);
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;
  localparam int CNT_W   = 32;

  logic               CLK = 1'b0;
  logic               Reset = 1'b1;
  logic [OP_W-1:0]    OpCode = '0;
  logic               zero = 1'b0;
  logic               sign = 1'b0;
  logic               PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, DBDataSrc;
  logic               RegWre, RD, WR, ExtSel, RegDst, halted;
  logic [1:0]         PCSrc;
  logic [ALUOP_W-1:0] ALUOp;
  logic [2:0]         state;
  logic [CNT_W-1:0]   retired;

  multicycle_control_unit #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .Reset(Reset), .OpCode(OpCode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .RegWre(RegWre), .RD(RD), .WR(WR),
    .ExtSel(ExtSel), .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .state(state), .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  st;
    logic        hl;
    logic        pcw;
    logic        irw;
    logic        imr;
    logic        srca;
    logic        srcb;
    logic        dbs;
    logic        rgw;
    logic        rd;
    logic        wr;
    logic        ext;
    logic        rdst;
    logic [1:0]  pcs;
    logic [2:0]  aop;
    logic [31:0] ret;
  } exp_t;

  typedef enum {K_NOP, K_R, K_I, K_LW, K_SW, K_BR, K_J, K_HALT} kind_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_ret = 0;

  logic [5:0] op_tab [16] = '{6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b011000,
                              6'b000010, 6'b010000, 6'b010010, 6'b011100,
                              6'b100110, 6'b100111, 6'b110000, 6'b110001,
                              6'b110010, 6'b111000, 6'b000111};

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010001, 6'b010011, 6'b011000: return K_R;
      6'b000010, 6'b010000, 6'b010010, 6'b011100:            return K_I;
      6'b100111: return K_LW;
      6'b100110: return K_SW;
      6'b110000, 6'b110001, 6'b110010: return K_BR;
      6'b111000: return K_J;
      6'b111111: return K_HALT;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic logic [2:0] aop_of(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110000, 6'b110001, 6'b110010: return 3'd1;
      6'b011000:            return 3'd2;
      6'b010011, 6'b010000: return 3'd3;
      6'b010001, 6'b010010: return 3'd4;
      6'b011100:            return 3'd5;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic taken(input logic [5:0] op, input logic z, input logic s);
    return (op == 6'b110000 && z) || (op == 6'b110001 && !z) || (op == 6'b110010 && s);
  endfunction

  function automatic exp_t idle_rec(input logic [2:0] st, input logic hl);
    exp_t e;
    e = '0;
    e.st  = st;
    e.hl  = hl;
    e.rd  = 1'b1;
    e.wr  = 1'b1;
    e.ret = model_ret;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Issue one instruction at the start of an IF cycle. The expected cycle
  // sequence comes straight from the per-class latency table; the selects
  // follow the instruction from ID onward.
  task automatic issue(input logic [5:0] op, input logic z, input logic s,
                       input bit reset_in_mem, input int hold);
    kind_t      k;
    logic [2:0] seq[$];
    exp_t       e;
    k = kind_of(op);
    OpCode = op;
    zero   = z;
    sign   = s;
    case (k)
      K_R, K_I: seq = '{3'd0, 3'd1, 3'd6, 3'd7};
      K_LW:     seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      K_SW:     seq = '{3'd0, 3'd1, 3'd2, 3'd3};
      K_BR:     seq = '{3'd0, 3'd1, 3'd5};
      default:  seq = '{3'd0, 3'd1};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      e = idle_rec(seq[i], 1'b0);
      if (i == 0) begin
        e.irw = 1'b1;
        e.imr = 1'b1;
      end else begin
        e.aop  = aop_of(op);
        e.srca = (op == 6'b011000);
        e.srcb = (k == K_I || k == K_LW || k == K_SW);
        e.ext  = !(op == 6'b010000 || op == 6'b010010);
        e.rdst = (k == K_R);
        e.dbs  = (op == 6'b100111);
        e.pcw  = (i == seq.size() - 1) && (k != K_HALT);
        if (seq[i] == 3'd1 && k == K_J) e.pcs = 2'b10;
        if (seq[i] == 3'd5 && taken(op, z, s)) e.pcs = 2'b01;
        if (seq[i] == 3'd3 && k == K_LW) e.rd = 1'b0;
        if (seq[i] == 3'd3 && k == K_SW) e.wr = 1'b0;
        if (seq[i] == 3'd7 || seq[i] == 3'd4) e.rgw = 1'b1;
      end
      q.push_back(e);
    end
    if (k == K_HALT) begin
      for (int i = 0; i <= hold; i++) q.push_back(idle_rec(3'd1, 1'b1));
      tick(2);
      OpCode = 6'($urandom);
      tick(hold);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      model_ret = 0;
    end else if (reset_in_mem && k == K_SW) begin
      tick(3);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      model_ret = 0;
    end else begin
      tick(seq.size());
      model_ret = model_ret + 1;
    end
  endtask

  exp_t mon_e, mon_a;

  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        mon_a = {state, halted, PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB,
                 DBDataSrc, RegWre, RD, WR, ExtSel, RegDst, PCSrc, ALUOp, retired};
        n_checks++;
        if (mon_a === mon_e) begin
          n_pass++;
        end else begin
          $display("FAIL cycle_outputs t=%0t op=%b state actual=%0d required=%0d fields actual=%h required=%h",
                   $time, OpCode, mon_a.st, mon_e.st, mon_a, mon_e);
        end
      end
    end
  end

  initial begin
    int r;
    tick(2);
    Reset = 1'b0;
    issue(6'b000000, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b100111, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b110000, 1'b1, 1'b0, 1'b0, 0);
    issue(6'b110000, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b110010, 1'b0, 1'b1, 1'b0, 0);
    issue(6'b110001, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b011000, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b010000, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b000111, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b111000, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b111111, 1'b0, 1'b0, 1'b0, 20);
    issue(6'b100110, 1'b0, 1'b0, 1'b0, 0);
    issue(6'b100110, 1'b0, 1'b0, 1'b1, 0);
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        issue(6'b111111, 1'($urandom), 1'($urandom), 1'b0, $urandom_range(1, 6));
      end else if (r < 9) begin
        issue(6'b100110, 1'($urandom), 1'($urandom), 1'b1, 0);
      end else if (r < 20) begin
        issue(6'($urandom), 1'($urandom), 1'($urandom), 1'b0, $urandom_range(1, 4));
      end else begin
        issue(op_tab[$urandom_range(0, 15)], 1'($urandom), 1'($urandom), 1'b0, 0);
      end
    end
    tick(3);
    n_checks++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL queue_drain actual=%0d entries left required=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
